seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan controller for a common-anode multi-digit 7-segment display.
// Define SEG_DEADTIME_EN to insert DEAD_CYC blank cycles after every digit.
module seg_scan_ctrl #(
    parameter int N_DIG      = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int REFRESH_HZ = 1_000,
    parameter int DEAD_CYC   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic [4*N_DIG-1:0]       digits,
    input  logic [N_DIG-1:0]         dp,
    output logic [6:0]               seg,
    output logic                     dp_n,
    output logic [N_DIG-1:0]         an,
    output logic [$clog2(N_DIG)-1:0] digit_idx,
    output logic                     frame_done
);

    localparam int TICKS = CLK_HZ / REFRESH_HZ;
    localparam int TW    = $clog2(TICKS);
    localparam int IW    = $clog2(N_DIG);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
    localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

    typedef enum logic [1:0] {IDLE, SHOW, DEAD} state_t;

    state_t               state, state_nx;
    logic [TW-1:0]        tick, tick_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic                 xfer;
    logic [4*N_DIG-1:0]   pend_dig, shown_dig;
    logic [N_DIG-1:0]     pend_dp, shown_dp;
    logic [6:0]           seg_nx;
    logic                 dp_n_nx;
    logic [N_DIG-1:0]     an_nx;
    logic [3:0]           nib;
    logic                 dp_bit;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h18;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Shown only refreshes from pending at a frame start, so frames never tear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= '0;
            idx       <= '0;
            pend_dig  <= '0;
            pend_dp   <= '0;
            shown_dig <= '0;
            shown_dp  <= '0;
        end else begin
            state <= state_nx;
            tick  <= tick_nx;
            idx   <= idx_nx;
            if (xfer) begin
                shown_dig <= pend_dig;
                shown_dp  <= pend_dp;
            end
            if (load) begin
                pend_dig <= digits;
                pend_dp  <= dp;
            end
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        idx_nx   = idx;
        xfer     = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            tick_nx  = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = SHOW;
                    tick_nx  = '0;
                    idx_nx   = '0;
                    xfer     = 1'b1;
                end
                SHOW: begin
                    if (tick == TICK_LAST) begin
                        tick_nx = '0;
                        if (idx == IDX_LAST) begin
                            idx_nx = '0;
                            xfer   = 1'b1;
                        end else begin
                            idx_nx = idx + 1'b1;
                        end
`ifdef SEG_DEADTIME_EN
                        state_nx = DEAD;
`else
                        state_nx = SHOW;
`endif
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                DEAD: begin
                    if (tick == DEAD_LAST) begin
                        state_nx = SHOW;
                        tick_nx  = '0;
                    end else begin
                        tick_nx = tick + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    tick_nx  = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_bit = 1'b0;
        an_nx  = '1;
        for (int k = 0; k < N_DIG; k++) begin
            if (idx == IW'(k)) begin
                nib      = shown_dig[4*k +: 4];
                dp_bit   = shown_dp[k];
                an_nx[k] = (state != SHOW);
            end
        end
        seg_nx     = (state == SHOW) ? decode(nib) : 7'h7F;
        dp_n_nx    = (state == SHOW) ? ~dp_bit : 1'b1;
        frame_done = en && (state == SHOW) &&
                     (tick == TICK_LAST) && (idx == IDX_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg       <= 7'h7F;
            dp_n      <= 1'b1;
            an        <= '1;
            digit_idx <= '0;
        end else begin
            seg       <= seg_nx;
            dp_n      <= dp_n_nx;
            an        <= an_nx;
            digit_idx <= idx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: frame-position reference model feeds a queue,
// a negedge monitor pops and compares every cycle.
module tb_seg_scan_ctrl;

    localparam int N    = 4;
    localparam int T    = 10;
`ifdef SEG_DEADTIME_EN
    localparam int D    = 2;
`else
    localparam int D    = 0;
`endif
    localparam int SLOT  = T + D;
    localparam int FRAME = N * SLOT;
    localparam int LAST  = (N - 1) * SLOT + T - 1;

    logic        clk = 0;
    logic        rst;
    logic        en, load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    seg_scan_ctrl #(
        .N_DIG(4), .CLK_HZ(1000), .REFRESH_HZ(100), .DEAD_CYC(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .digits(digits), .dp(dp), .seg(seg), .dp_n(dp_n),
        .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic [1:0] idx;
        logic       fd;
    } obs_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   started = 0;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h78, 7'h00, 7'h18, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: a running flag plus a position inside the frame.
    bit          running;
    int          pos;
    logic [15:0] pend_d, shown_d;
    logic [3:0]  pend_p, shown_p;

    function automatic obs_t view();
        obs_t o;
        int   dig, off;
        o = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, idx: 2'd0, fd: 1'b0};
        if (running) begin
            dig   = pos / SLOT;
            off   = pos % SLOT;
            o.idx = 2'((off < T) ? dig : (dig + 1) % N);
            if (off < T) begin
                o.an   = ~(4'b1 << dig);
                o.seg  = segtab[shown_d[4*dig +: 4]];
                o.dp_n = ~shown_p[dig];
            end
        end
        return o;
    endfunction

    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                running = 0; pos = 0;
                pend_d = 0; pend_p = 0; shown_d = 0; shown_p = 0;
                started = 0;
            end else begin
                e = view();
                if (!en) running = 0;
                else if (!running) begin
                    running = 1; pos = 0;
                    shown_d = pend_d; shown_p = pend_p;
                end else begin
                    if (pos == LAST) begin
                        shown_d = pend_d; shown_p = pend_p;
                    end
                    pos = (pos + 1) % FRAME;
                end
                if (load) begin
                    pend_d = digits; pend_p = dp;
                end
                e.fd = running && (pos == LAST) && en;
                sb.push_back(e);
                started = 1;
            end
        end
    end

    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            if (!rst && started) begin
                a = '{an: an, seg: seg, dp_n: dp_n, idx: digit_idx, fd: frame_done};
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_empty t=%0t got %h", $time, a);
                end else begin
                    e = sb.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL scan t=%0t got an=%h seg=%h dpn=%b idx=%0d fd=%b exp an=%h seg=%h dpn=%b idx=%0d fd=%b",
                                 $time, a.an, a.seg, a.dp_n, a.idx, a.fd,
                                 e.an, e.seg, e.dp_n, e.idx, e.fd);
                    end
                end
                n_vec++;
                if ($countones(~an) > 1) begin
                    n_bad++;
                    $display("FAIL anode_onehot t=%0t got an=%h exp at most one low", $time, an);
                end
            end
        end
    end

    task automatic cyc(input bit e, input bit l, input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        #1;
        en = e; load = l; digits = d; dp = p;
    endtask

    task automatic chk_dark(input string name);
        n_vec++;
        if ({an, seg, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL %s got an=%h seg=%h dpn=%b fd=%b exp an=f seg=7f dpn=1 fd=0",
                     name, an, seg, dp_n, frame_done);
        end
    endtask

    initial begin
        rst = 1; en = 0; load = 0; digits = 0; dp = 0;
        repeat (2) @(negedge clk);
        chk_dark("reset_state");
        #1 rst = 0;
        repeat (3) cyc(0, 0, 16'h0, 4'h0);

        cyc(0, 1, 16'h1A3F, 4'b0010);
        cyc(1, 0, 16'h0, 4'h0);
        repeat (25) cyc(1, 0, 16'h0, 4'h0);
        cyc(1, 1, 16'h0000, 4'h0);
        repeat (110) cyc(1, 0, 16'h0, 4'h0);

        cyc(1, 1, 16'h9C5E, 4'b1001);
        repeat (60) cyc(1, 0, 16'h0, 4'h0);
        cyc(0, 0, 16'h0, 4'h0);
        repeat (3) cyc(0, 0, 16'h0, 4'h0);
        repeat (50) cyc(1, 0, 16'h0, 4'h0);

        repeat (17) cyc(1, 0, 16'h0, 4'h0);
        @(negedge clk);
        #1 rst = 1;
        #1 chk_dark("reset_midscan");
        sb.delete();
        @(negedge clk);
        #1 rst = 0;
        repeat (60) cyc(1, 0, 16'h0, 4'h0);

        repeat (4000)
            cyc(($urandom % 80) != 0, ($urandom % 12) == 0,
                16'($urandom), 4'($urandom));
        repeat (2) cyc(1, 0, 16'h0, 4'h0);
        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
